sad_vector_builder: RTL

//  Builds the wide SAD difference vector consumed by linecounter. Streams image-line
//  and template-line words in, XORs them word by word and packs the result into a
//  VEC_W-bit buffer. Presents the completed vector with a valid/ready handshake.

---
 rtl/sad_vector_builder.sv | 54 +++++
 1 files changed

// File: rtl/sad_vector_builder.sv
// sad_vector_builder: XORs image/template beats into a VEC_W-bit difference vector
// and presents it downstream with a valid/ready handshake.
module sad_vector_builder #(
  parameter int VEC_W = 4000,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] img_word,
  input  logic [WORD_W-1:0] tpl_word,
  input  logic              in_last,
  output logic [VEC_W-1:0]  d_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);
  localparam int NWORDS = (VEC_W + WORD_W - 1) / WORD_W;
  localparam int IW = NWORDS > 1 ? $clog2(NWORDS) : 1;
  typedef enum logic {FILL, HOLD} state_t;
  state_t state;
  logic [IW-1:0] idx;
  logic last_beat, acc;
  logic [31:0] sh;
  logic [VEC_W-1:0] mask, data;
  assign last_beat = idx == IW'(NWORDS - 1);
  assign acc = in_valid && state == FILL && !clr;
  assign sh = 32'(idx) * 32'(WORD_W);
  // shifting into a VEC_W-wide field drops the final beat's bits above VEC_W-1
  assign mask = VEC_W'({WORD_W{1'b1}}) << sh;
  assign data = VEC_W'(img_word ^ tpl_word) << sh;
  assign in_ready = state == FILL;
  assign out_valid = state == HOLD;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      idx <= '0;
      d_out <= '0;
      err <= 1'b0;
    end else begin
      if (acc && in_last != last_beat) err <= 1'b1;
      if (acc) begin
        d_out <= (d_out & ~mask) | data;
        idx <= last_beat ? '0 : idx + 1'b1;
      end
      if (clr) begin
        state <= FILL;
        idx <= '0;
      end else if (acc && last_beat) state <= HOLD;
      else if (state == HOLD && out_ready) state <= FILL;
    end
endmodule
